spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Single-clock SPI master that drives the SS_n, MOSI and MISO serial link into the team's SPI slave / RAM-bridge path.
- Accepts 10-bit command frames from a host-side valid/ready port: 2 control bits and FRAME_WIDTH data bits.
- Serialises each frame MSB-first, one bit per clk. No SCK is used; both ends share clk.
- For read-data commands (ctrl = 2'b11), waits a fixed turnaround, captures FRAME_WIDTH bits from MISO and returns them on a one-cycle response strobe.

Parameters:
- FRAME_WIDTH, 8: data bits per frame. Command frame width is FRAME_WIDTH+2; response width is FRAME_WIDTH.
- RD_WAIT, 2: idle cycles between the last MOSI frame bit and the first MISO sample. Legal range 0..255.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  host presents a command frame
- cmd_data  in  FRAME_WIDTH+2  command frame; [FRAME_WIDTH+1:FRAME_WIDTH] = ctrl, remainder = payload
- cmd_ready  out  1  high only in IDLE and not in reset; transfer occurs when cmd_valid && cmd_ready
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid
- rsp_data  out  FRAME_WIDTH  captured MISO byte, MSB first
- busy  out  1  high in every state except IDLE
- SS_n  out  1  slave select, active low, registered
- MOSI  out  1  serial data to slave, registered
- MISO  in  1  serial data from slave

Behaviour:
- Reset values: SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0, cmd_ready=0, busy=0, state=IDLE, counters=0.
- rst mid-transfer forces these values on the next edge with no rsp_valid; the slave sees SS_n rise and returns to its idle state.
- Frame handling:
  - Accepted frame is latched into a shift register.
  - cmd_data changes after acceptance have no effect.
  - Back-to-back commands are allowed: cmd_ready returns in the cycle after DONE.
- States and per-cycle behaviour (acceptance on the edge ending cycle t):
  - IDLE: SS_n=1, MOSI=0, cmd_ready=1. On accept -> SELECT.
  - SELECT (t+1): SS_n=0, MOSI=0. Gives the slave one cycle to leave its idle state. -> CMD.
  - CMD (t+2): MOSI = ctrl MSB (cmd_data[FRAME_WIDTH+1]), the read/write decision bit. -> SHIFT.
  - SHIFT (t+3..t+12 for FRAME_WIDTH=8):
    - MOSI drives all FRAME_WIDTH+2 frame bits MSB-first, including the ctrl MSB a second time.
    - Bit counter runs 0..FRAME_WIDTH+1.
    - On the last bit: -> WAIT if ctrl==2'b11, else -> DONE.
  - WAIT: MOSI=0, SS_n=0 for exactly RD_WAIT cycles. RD_WAIT=0 goes straight to READ.
  - READ: SS_n=0, MOSI=0 for FRAME_WIDTH cycles.
    - MISO is sampled on the edge ending each READ cycle and shifted in at the LSB.
    - After the last sample -> DONE.
  - DONE (1 cycle): SS_n=1, MOSI=0. rsp_valid=1 for read-data commands only, with rsp_data = the captured byte. -> IDLE.
- rsp_data holds its value until the next read-data completion or reset.
- SS_n is low for 12 cycles on write/read-address commands, and 12+RD_WAIT+FRAME_WIDTH cycles on read-data. Both figures are for FRAME_WIDTH=8.
- SS_n is always high for at least 2 cycles (DONE, then IDLE) between transactions.
- cmd_valid asserted while busy is ignored; the host must hold it until cmd_ready.

Optional Feature:
- Macro: SPI_MASTER_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort high in SELECT, CMD, SHIFT, WAIT or READ -> next cycle enters DONE with SS_n=1 and rsp_valid=0, then IDLE.
  - abort is ignored in IDLE and DONE.
  - rsp_data is left unchanged.
- When undefined: port absent; transactions always run to completion.

Test Plan:
1. Reset: hold rst 3 cycles mid-SHIFT -> SS_n=1, MOSI=0, cmd_ready=0 during reset; cmd_ready=1 the first cycle after release; no rsp_valid.
2. Write-address cmd_data=10'h0A5 -> SS_n low 12 cycles; MOSI sequence 0 (SELECT), 0 (CMD), then 0,0,1,0,1,0,0,1,0,1; DONE SS_n=1; no rsp_valid; cmd_ready back at t+14.
3. Read-data cmd_data=10'h300, RD_WAIT=2, slave model drives 8'hC3 starting the 3rd cycle after the last MOSI bit -> MOSI 1,1,1,0,0,0,0,0,0,0,0; SS_n low 22 cycles; rsp_valid one pulse; rsp_data=8'hC3.
4. Back-to-back: cmd_valid held high with 10'h1FF then 10'h2AA -> exactly one SS_n high gap of 2 cycles; frames serialised in order; cmd_ready never high while busy.
5. RD_WAIT=0 build: read-data with MISO pattern 8'h5A -> first MISO sample on the edge ending the cycle right after the last MOSI bit; rsp_data=8'h5A.
6. SPI_MASTER_ABORT_EN: abort pulsed at 5th SHIFT cycle of a read-data frame -> SS_n=1 next cycle; no rsp_valid; rsp_data keeps previous value 8'hC3; next command runs normally.

Source files
------------

// File: rtl/spi_master.sv
// spi_master: single-clock SPI master. Serialises host command frames onto SS_n/MOSI and
//   captures a FRAME_WIDTH-bit reply from MISO for read-data commands (ctrl == 2'b11).
// Latency: SS_n falls 1 cycle after accept. Writes/read-address: 12 cycles low (FRAME_WIDTH=8),
//   then DONE. Reads: 12+RD_WAIT+FRAME_WIDTH cycles low, then DONE with a one-cycle rsp_valid.
// Backpressure: cmd_ready is high only in IDLE and outside reset. The host holds cmd_valid
//   until accepted. No response backpressure: rsp_valid is a single-cycle strobe.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   cmd_valid/ready host command handshake; cmd_data = {ctrl[1:0], payload[FRAME_WIDTH-1:0]}
//   rsp_valid/data  read-data response strobe and captured byte (held until next read/reset)
//   busy            high whenever the engine is not in IDLE
//   SS_n, MOSI      registered serial outputs to the slave
//   MISO            serial input from the slave, sampled during READ
//   abort           (only with SPI_MASTER_ABORT_EN) cuts an active transfer short via DONE
//
// Optional feature macro: SPI_MASTER_ABORT_EN adds the abort input.
module spi_master #(
  parameter int FRAME_WIDTH = 8,
  parameter int RD_WAIT     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic [FRAME_WIDTH+1:0] cmd_data,
  output logic                   cmd_ready,
  output logic                   rsp_valid,
  output logic [FRAME_WIDTH-1:0] rsp_data,
  output logic                   busy,
  output logic                   SS_n,
  output logic                   MOSI,
  input  logic                   MISO
`ifdef SPI_MASTER_ABORT_EN
  ,
  input  logic                   abort
`endif
);

  localparam int CMD_W = FRAME_WIDTH + 2;
  localparam int CNT_W = $clog2(CMD_W);

  // Last value of the bit counter in SHIFT (frame bit 0) and in READ (last MISO sample).
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] LAST_READ  = CNT_W'(FRAME_WIDTH - 1);
  // WAIT is never entered when RD_WAIT is 0, so the terminal count only matters for RD_WAIT>0.
  localparam logic [7:0]       WAIT_LAST  = 8'((RD_WAIT > 0) ? (RD_WAIT - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CMD,
    S_SHIFT,
    S_WAIT,
    S_READ,
    S_DONE
  } state_e;

  state_e                 state_q;
  logic                   ss_n_q;
  logic                   mosi_q;
  logic                   rsp_valid_q;
  logic [FRAME_WIDTH-1:0] rsp_data_q;
  logic [CMD_W-1:0]       shreg_q;
  logic [FRAME_WIDTH-1:0] rx_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [7:0]             wait_cnt_q;
  logic                   rd_cmd_q;

  // Next value of the receive shifter: MISO enters at the LSB so the first sample ends up as MSB.
  logic [FRAME_WIDTH-1:0] rx_d;
  // Transmit shifter advanced by one bit; MSB always holds the next bit to drive.
  logic [CMD_W-1:0]       shreg_d;

  assign rx_d    = {rx_q[FRAME_WIDTH-2:0], MISO};
  assign shreg_d = {shreg_q[CMD_W-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      shreg_q     <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      rd_cmd_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ss_n_q <= 1'b1;
          mosi_q <= 1'b0;
          if (cmd_valid) begin
            // Frame is captured here; later cmd_data changes cannot reach the wire.
            shreg_q  <= cmd_data;
            rd_cmd_q <= (cmd_data[CMD_W-1 -: 2] == 2'b11);
            ss_n_q   <= 1'b0;
            state_q  <= S_SELECT;
          end
        end

        // One quiet cycle with SS_n low so the slave can leave its idle state.
        S_SELECT: begin
          mosi_q  <= shreg_q[CMD_W-1];
          state_q <= S_CMD;
        end

        // CMD shows the read/write decision bit early; SHIFT then repeats it as the frame MSB,
        // so the shifter is not advanced on the way into CMD.
        S_CMD: begin
          mosi_q    <= shreg_q[CMD_W-1];
          shreg_q   <= shreg_d;
          bit_cnt_q <= '0;
          state_q   <= S_SHIFT;
        end

        S_SHIFT: begin
          if (bit_cnt_q == LAST_SHIFT) begin
            mosi_q     <= 1'b0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            if (!rd_cmd_q) begin
              ss_n_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (RD_WAIT == 0) begin
              state_q <= S_READ;
            end else begin
              state_q <= S_WAIT;
            end
          end else begin
            mosi_q    <= shreg_q[CMD_W-1];
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end

        // Turnaround for the slave to fetch read data; SS_n stays low, MOSI idles at 0.
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_q <= S_READ;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        S_READ: begin
          rx_q <= rx_d;
          if (bit_cnt_q == LAST_READ) begin
            ss_n_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rx_d;
            bit_cnt_q   <= '0;
            state_q     <= S_DONE;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end

        // Guarantees a second SS_n-high cycle before the next frame can start.
        S_DONE: begin
          ss_n_q    <= 1'b1;
          mosi_q    <= 1'b0;
          bit_cnt_q <= '0;
          state_q   <= S_IDLE;
        end

        default: begin
          ss_n_q  <= 1'b1;
          mosi_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase

`ifdef SPI_MASTER_ABORT_EN
      // Abort overrides whatever the active state scheduled, including a READ completion:
      // no response strobe and the previous response byte is retained.
      if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
        state_q     <= S_DONE;
        ss_n_q      <= 1'b1;
        mosi_q      <= 1'b0;
        rsp_valid_q <= 1'b0;
        rsp_data_q  <= rsp_data_q;
        bit_cnt_q   <= '0;
      end
`endif
    end
  end

  // Ready is combinational so it drops in the same cycle reset is asserted.
  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE);
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  localparam int FW  = 8;
  localparam int RW0 = 2;
  localparam int RW1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance inputs (instance 0: RD_WAIT=2, instance 1: RD_WAIT=0).
  logic [1:0]    rst_r;
  logic [1:0]    cmd_valid_r;
  logic [1:0]    miso_r;
  logic [FW+1:0] cmd_data_r [2];
  logic [FW-1:0] slave_byte [2];
`ifdef SPI_MASTER_ABORT_EN
  logic [1:0]    abort_r;
`endif

  logic [1:0]    cmd_ready_w, rsp_valid_w, busy_w, ss_n_w, mosi_w;
  logic [FW-1:0] rsp_data_w [2];

  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic tmo_flag = 1'b0;
  int   pin_id = 0;
  int   pin_dut = 0;

  spi_master #(.FRAME_WIDTH(FW), .RD_WAIT(RW0)) u_dut0 (
    .clk(clk), .rst(rst_r[0]), .cmd_valid(cmd_valid_r[0]), .cmd_data(cmd_data_r[0]),
    .cmd_ready(cmd_ready_w[0]), .rsp_valid(rsp_valid_w[0]), .rsp_data(rsp_data_w[0]),
    .busy(busy_w[0]), .SS_n(ss_n_w[0]), .MOSI(mosi_w[0]), .MISO(miso_r[0])
`ifdef SPI_MASTER_ABORT_EN
    , .abort(abort_r[0])
`endif
  );

  spi_master #(.FRAME_WIDTH(FW), .RD_WAIT(RW1)) u_dut1 (
    .clk(clk), .rst(rst_r[1]), .cmd_valid(cmd_valid_r[1]), .cmd_data(cmd_data_r[1]),
    .cmd_ready(cmd_ready_w[1]), .rsp_valid(rsp_valid_w[1]), .rsp_data(rsp_data_w[1]),
    .busy(busy_w[1]), .SS_n(ss_n_w[1]), .MOSI(mosi_w[1]), .MISO(miso_r[1])
`ifdef SPI_MASTER_ABORT_EN
    , .abort(abort_r[1])
`endif
  );

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt = vec_cnt + 1;
    if (act !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Reference model: k = cycles since acceptance (0 = idle, 1 = first SS_n-low cycle).
  // Transaction length and every output are plain functions of k and the accepted frame.
  int            k        [2] = '{0, 0};
  logic [FW+1:0] frame_m  [2] = '{'0, '0};
  logic [FW-1:0] mbyte    [2] = '{'0, '0};
  logic [FW-1:0] rsp_m    [2] = '{'0, '0};
  logic          aborted  [2] = '{1'b0, 1'b0};
  logic          known    [2] = '{1'b0, 1'b0};
  int            low_cnt  [2] = '{0, 0};
  logic [11:0]   mosi_rec [2] = '{'0, '0};

  always @(negedge clk) begin
    int          rw, len, pin_low;
    logic        rd, e_ss, e_mosi, e_rv;
    logic [11:0] pin_seq;
    logic [7:0]  pin_rsp;
    chk("host_timeout", 0, {31'd0, tmo_flag}, 32'd0);
    for (int d = 0; d < 2; d++) begin
      rw  = (d == 0) ? RW0 : RW1;
      rd  = (frame_m[d][FW+1:FW] == 2'b11);
      len = rd ? (FW + 4 + rw + FW) : (FW + 4);
      case (pin_id)
        1:       begin pin_low = 12; pin_seq = 12'h0A5; pin_rsp = 8'h00; end
        2:       begin pin_low = 22; pin_seq = 12'h700; pin_rsp = 8'hC3; end
        default: begin pin_low = 20; pin_seq = 12'h700; pin_rsp = 8'h5A; end
      endcase
      if (known[d]) begin
        e_ss   = !(k[d] >= 1 && k[d] <= len);
        e_mosi = (k[d] == 2) ? frame_m[d][FW+1] :
                 (k[d] >= 3 && k[d] <= FW + 4) ? 1'(frame_m[d] >> (FW + 4 - k[d])) : 1'b0;
        e_rv   = (k[d] == len + 1) && rd && !aborted[d];
        chk("ss_n",      d, {31'd0, ss_n_w[d]},      {31'd0, e_ss});
        chk("mosi",      d, {31'd0, mosi_w[d]},      {31'd0, e_mosi});
        chk("busy",      d, {31'd0, busy_w[d]},      {31'd0, k[d] != 0});
        chk("rsp_valid", d, {31'd0, rsp_valid_w[d]}, {31'd0, e_rv});
        chk("rsp_data",  d, {24'd0, rsp_data_w[d]},  {24'd0, rsp_m[d]});
        chk("cmd_ready", d, {31'd0, cmd_ready_w[d]}, {31'd0, (k[d] == 0) && !rst_r[d]});
        // Literal pins for the directed frames, independent of the model arithmetic.
        if (ss_n_w[d] == 1'b0) begin
          low_cnt[d] = low_cnt[d] + 1;
          if (low_cnt[d] <= 12) mosi_rec[d] = {mosi_rec[d][10:0], mosi_w[d]};
        end else begin
          if (low_cnt[d] != 0 && pin_id != 0 && pin_dut == d) begin
            chk("pin_ss_low_cycles", d, low_cnt[d], pin_low);
            chk("pin_mosi_sequence", d, {20'd0, mosi_rec[d]}, {20'd0, pin_seq});
          end
          low_cnt[d]  = 0;
          mosi_rec[d] = '0;
        end
        if (rsp_valid_w[d] && pin_id > 1 && pin_dut == d)
          chk("pin_rsp_data", d, {24'd0, rsp_data_w[d]}, {24'd0, pin_rsp});
      end

      // Slave: drives the reply MSB first during the read window, noise everywhere else.
      if (rd && !aborted[d] && k[d] >= FW + 5 + rw && k[d] < FW + 5 + rw + FW)
        miso_r[d] = 1'(mbyte[d] >> (FW - 1 - (k[d] - FW - 5 - rw)));
      else
        miso_r[d] = 1'($urandom);

      // Advance the model with this cycle's inputs.
      if (rst_r[d]) begin
        k[d] = 0; aborted[d] = 1'b0; rsp_m[d] = '0; known[d] = 1'b1;
      end else if (known[d]) begin
        if (k[d] == 0) begin
          if (cmd_valid_r[d]) begin
            k[d] = 1; frame_m[d] = cmd_data_r[d]; mbyte[d] = slave_byte[d];
          end
        end
`ifdef SPI_MASTER_ABORT_EN
        else if (abort_r[d] && k[d] <= len) begin
          k[d] = len + 1; aborted[d] = 1'b1;
        end
`endif
        else if (k[d] == len + 1) begin
          k[d] = 0; aborted[d] = 1'b0;
        end else begin
          k[d] = k[d] + 1;
          if (k[d] == len + 1 && rd) rsp_m[d] = mbyte[d];
        end
      end
    end
  end

  task automatic send(input int d, input logic [FW+1:0] data, input logic [FW-1:0] sb);
    logic acc;
    acc = 1'b0;
    cmd_data_r[d]  = data;
    slave_byte[d]  = sb;
    cmd_valid_r[d] = 1'b1;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      acc = cmd_ready_w[d];
      @(posedge clk); #1;
    end
    cmd_valid_r[d] = 1'b0;
    if (!acc) tmo_flag = 1'b1;
  endtask

  task automatic wait_idle(input int d);
    logic idle;
    idle = 1'b0;
    for (int n = 0; n < 400 && !idle; n++) begin
      @(negedge clk);
      idle = !busy_w[d];
    end
    if (!idle) tmo_flag = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_r = 2'b11;
    cmd_valid_r = 2'b00;
    cmd_data_r[0] = '0; cmd_data_r[1] = '0;
    slave_byte[0] = '0; slave_byte[1] = '0;
`ifdef SPI_MASTER_ABORT_EN
    abort_r = 2'b00;
`endif
    repeat (3) @(posedge clk);
    #1 rst_r = 2'b00;

    // Write-address frame.
    pin_dut = 0; pin_id = 1;
    send(0, 10'h0A5, 8'h00); wait_idle(0); pin_id = 0;
    // Read-data frame, RD_WAIT=2.
    pin_id = 2;
    send(0, 10'h300, 8'hC3); wait_idle(0); pin_id = 0;
    // Reset held for 3 cycles in the middle of SHIFT.
    send(0, 10'h155, 8'h00);
    repeat (4) @(posedge clk);
    #1 rst_r[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_r[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Back-to-back: valid held across both frames.
    send(0, 10'h1FF, 8'h00); send(0, 10'h2AA, 8'h00); wait_idle(0);
    // Read-data with zero turnaround on the second instance.
    pin_dut = 1; pin_id = 3;
    send(1, 10'h300, 8'h5A); wait_idle(1); pin_id = 0;
`ifdef SPI_MASTER_ABORT_EN
    send(0, 10'h3F0, 8'hC3); wait_idle(0);
    send(0, 10'h300, 8'h77);
    repeat (6) @(posedge clk);
    #1 abort_r[0] = 1'b1;
    @(posedge clk);
    #1 abort_r[0] = 1'b0;
    wait_idle(0);
    send(0, 10'h0A5, 8'h00); wait_idle(0);
`endif

    // Random traffic on both instances; the model follows every cycle.
    for (int c = 0; c < 4000; c++) begin
      for (int d = 0; d < 2; d++) begin
        rst_r[d]       = ($urandom_range(0, 499) == 0);
        cmd_valid_r[d] = ($urandom_range(0, 2) != 0);
        cmd_data_r[d]  = 10'($urandom);
        slave_byte[d]  = 8'($urandom);
`ifdef SPI_MASTER_ABORT_EN
        abort_r[d]     = ($urandom_range(0, 39) == 0);
`endif
      end
      @(posedge clk); #1;
    end
    rst_r = 2'b00;
    cmd_valid_r = 2'b00;
`ifdef SPI_MASTER_ABORT_EN
    abort_r = 2'b00;
`endif
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
